// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - oversampled UART with TX/RX FIFOs behind an nCS/nWR/nRD strobe bus
module uart_fifo_bridge #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       RxD,
  output logic       TxD,
  input  logic       nCS,
  input  logic       nWR,
  input  logic       nRD,
  input  logic       ADDR,
  input  logic [7:0] WrData,
  output logic [7:0] RdData,
  output logic       RDY,
  output logic       IRQ
);
  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int DW      = DATA_BITS;
  localparam logic [4:0] STOP_LAST = 5'(16 * STOP_BITS - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic       ODD       = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          wr_prev, rd_prev, wr_commit, rd_commit, flag_clr;
  logic [AW:0]   tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [DW-1:0] tx_mem [FIFO_DEPTH];
  logic [DW-1:0] rx_mem [FIFO_DEPTH];
  logic [DW-1:0] tx_head, rx_head;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_pop, tx_do_push, rx_pop, rx_do_pop, rx_push, rx_do_push;
  state_t        tx_state, rx_state;
  logic [4:0]    tx_cnt;
  logic [2:0]    tx_bit, rx_bit;
  logic [DW-1:0] tx_shift;
  logic          tx_par, tx_idle;
  logic          rx_s1, rx_s2, rx_wait_high;
  logic [3:0]    rx_cnt;
  logic [7:0]    rx_data;
  logic          rx_sample, pe_set, fe_set, oe_set;
  logic          pe, fe, oe;
  logic [7:0]    status;

  assign tick = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) div_cnt <= '0;
    else       div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  assign wr_commit = !nCS && !wr_prev && nWR && !ADDR;
  assign rd_commit = !nCS && !rd_prev && nRD;
  assign flag_clr  = rd_commit && ADDR;

  // Pointer MSB differs and index bits match when full.
  assign tx_empty   = (tx_wptr == tx_rptr);
  assign tx_full    = ((tx_wptr ^ tx_rptr) == {1'b1, {AW{1'b0}}});
  assign rx_empty   = (rx_wptr == rx_rptr);
  assign rx_full    = ((rx_wptr ^ rx_rptr) == {1'b1, {AW{1'b0}}});
  assign tx_head    = tx_mem[tx_rptr[AW-1:0]];
  assign rx_head    = rx_mem[rx_rptr[AW-1:0]];
  assign tx_pop     = tick && !tx_empty &&
                      (tx_state == S_IDLE || (tx_state == S_STOP && tx_cnt == STOP_LAST));
  assign tx_do_push = wr_commit && (!tx_full || tx_pop);
  assign rx_pop     = rd_commit && !ADDR;
  assign rx_do_pop  = rx_pop && !rx_empty;
  assign rx_do_push = rx_push && (!rx_full || rx_do_pop);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem[i] <= '0;
        rx_mem[i] <= '0;
      end
    end else begin
      if (tx_do_push) begin
        tx_mem[tx_wptr[AW-1:0]] <= WrData[DW-1:0];
        tx_wptr <= tx_wptr + 1'b1;
      end
      if (tx_pop) tx_rptr <= tx_rptr + 1'b1;
      if (rx_do_push) begin
        rx_mem[rx_wptr[AW-1:0]] <= rx_data[DW-1:0];
        rx_wptr <= rx_wptr + 1'b1;
      end
      if (rx_do_pop) rx_rptr <= rx_rptr + 1'b1;
    end
  end

  assign tx_idle = tx_empty && (tx_state == S_IDLE);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      tx_state <= S_IDLE;
      TxD      <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else if (tick) begin
      tx_cnt <= tx_cnt + 5'd1;
      if (tx_pop) begin
        tx_shift <= tx_head;
        tx_par   <= (^tx_head) ^ ODD;
        TxD      <= 1'b0;
        tx_cnt   <= '0;
        tx_state <= S_START;
      end else begin
        case (tx_state)
          S_IDLE: TxD <= 1'b1;
          S_START: if (tx_cnt == 5'd15) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            TxD      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= S_DATA;
          end
          S_DATA: if (tx_cnt == 5'd15) begin
            tx_cnt <= '0;
            if (tx_bit == BIT_LAST) begin
              if (PARITY != 0) begin
                TxD      <= tx_par;
                tx_state <= S_PARITY;
              end else begin
                TxD      <= 1'b1;
                tx_state <= S_STOP;
              end
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              TxD      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end
          S_PARITY: if (tx_cnt == 5'd15) begin
            tx_cnt   <= '0;
            TxD      <= 1'b1;
            tx_state <= S_STOP;
          end
          S_STOP: if (tx_cnt == STOP_LAST) begin
            tx_cnt   <= '0;
            tx_state <= S_IDLE;
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_sample = tick && (rx_cnt == 4'd15);
  assign rx_push   = rx_sample && (rx_state == S_STOP) && rx_s2;
  assign fe_set    = rx_sample && (rx_state == S_STOP) && !rx_s2;
  assign pe_set    = rx_sample && (rx_state == S_PARITY) && (rx_s2 != ((^rx_data[DW-1:0]) ^ ODD));
  assign oe_set    = rx_push && !rx_do_push;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_data      <= '0;
      rx_wait_high <= 1'b0;
    end else begin
      rx_s1 <= RxD;
      rx_s2 <= rx_s1;
      if (tick) begin
        rx_cnt <= rx_cnt + 4'd1;
        case (rx_state)
          S_IDLE: begin
            rx_cnt <= '0;
            if (rx_s2) rx_wait_high <= 1'b0;
            else if (!rx_wait_high) rx_state <= S_START;
          end
          S_START: if (rx_cnt == 4'd7) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end
          S_DATA: if (rx_cnt == 4'd15) begin
            rx_data[rx_bit] <= rx_s2;
            if (rx_bit == BIT_LAST) rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            else                    rx_bit   <= rx_bit + 3'd1;
          end
          S_PARITY: if (rx_cnt == 4'd15) rx_state <= S_STOP;
          S_STOP: if (rx_cnt == 4'd15) begin
            rx_state <= S_IDLE;
            // A low stop bit may be a break; hold off until the line idles.
            if (!rx_s2) rx_wait_high <= 1'b1;
          end
          default: rx_state <= S_IDLE;
        endcase
      end
    end
  end

  assign status = {pe, fe, oe, rx_full, tx_full, rx_s2, tx_idle, !rx_empty};

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_prev <= 1'b1;
      rd_prev <= 1'b1;
      pe      <= 1'b0;
      fe      <= 1'b0;
      oe      <= 1'b0;
      RdData  <= 8'h00;
      RDY     <= 1'b1;
      IRQ     <= 1'b0;
    end else begin
      wr_prev <= nWR;
      rd_prev <= nRD;
      pe      <= pe_set || (pe && !flag_clr);
      fe      <= fe_set || (fe && !flag_clr);
      oe      <= oe_set || (oe && !flag_clr);
      if (!nCS && !nRD) RdData <= ADDR ? status : (rx_empty ? 8'h00 : 8'(rx_head));
      RDY     <= !(wr_commit || rd_commit);
      IRQ     <= !rx_empty || pe || fe || oe;
    end
  end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb/tb_uart_fifo_bridge.sv - scoreboard bench for uart_fifo_bridge at one tick per clock
module tb_uart_fifo_bridge;
  logic       clk = 1'b0, nRST = 1'b0, RxD = 1'b1;
  logic       nCS = 1'b1, nWR = 1'b1, nRD = 1'b1, ADDR = 1'b0;
  logic [7:0] WrData = 8'h00;
  logic       TxD, RDY, IRQ;
  logic [7:0] RdData;

  int n_vec = 0, n_err = 0, cyc = 0;
  logic mon_on = 1'b1;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int start_q[$];

  typedef struct {
    logic [7:0] d;
    logic       bad_par;
    logic       bad_stop;
    logic [7:0] stat;
  } rx_vec_t;

  uart_fifo_bridge #(.CLK_HZ(1600000), .BAUD(100000)) dut (
    .clk(clk), .nRST(nRST), .RxD(RxD), .TxD(TxD), .nCS(nCS), .nWR(nWR), .nRD(nRD),
    .ADDR(ADDR), .WrData(WrData), .RdData(RdData), .RDY(RDY), .IRQ(IRQ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] d);
    @(negedge clk); nCS = 1'b0; ADDR = 1'b0; WrData = d; nWR = 1'b0;
    @(negedge clk); nWR = 1'b1;
    @(negedge clk); nCS = 1'b1;
  endtask

  task automatic cpu_read(input logic a, output logic [7:0] d);
    @(negedge clk); nCS = 1'b0; ADDR = a; nRD = 1'b0;
    @(negedge clk); d = RdData; nRD = 1'b1;
    @(negedge clk); nCS = 1'b1;
  endtask

  task automatic wait_tx_idle(input string name);
    logic [7:0] s;
    int n;
    n = 0;
    do begin
      cpu_read(1'b1, s);
      n++;
    end while (!s[1] && n < 2000);
    check(name, s[1], 1);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); RxD = bits[i];
      repeat (15) @(negedge clk);
    end
    @(negedge clk); RxD = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  // Decodes every frame on TxD and checks it against the write-order scoreboard.
  initial begin : tx_mon
    logic [7:0] d, e;
    logic st, p, sp;
    forever begin
      @(negedge clk);
      if (nRST && TxD == 1'b0) begin
        start_q.push_back(cyc);
        repeat (8) @(negedge clk); st = TxD;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk); d[i] = TxD;
        end
        repeat (16) @(negedge clk); p = TxD;
        repeat (16) @(negedge clk); sp = TxD;
        if (mon_on) begin
          if (tx_exp.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_unexpected: got frame %02h expected none", d);
          end else begin
            e = tx_exp.pop_front();
            check("tx_data", d, e);
            check("tx_frame_bits", {st, p, sp}, {1'b0, ~^e, 1'b1});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] s;
    logic [7:0] tx_tab[4];
    rx_vec_t rx_tab[5];
    int bad;

    tx_tab = '{8'h00, 8'hFF, 8'h3C, 8'h81};
    rx_tab[0] = '{8'h3C, 1'b0, 1'b0, 8'h07};
    rx_tab[1] = '{8'h55, 1'b1, 1'b0, 8'h87};
    rx_tab[2] = '{8'hA0, 1'b0, 1'b1, 8'h46};
    rx_tab[3] = '{8'h00, 1'b0, 1'b0, 8'h07};
    rx_tab[4] = '{8'hFF, 1'b0, 1'b0, 8'h07};

    repeat (3) @(negedge clk);
    check("rst_txd", TxD, 1);
    check("rst_rdy", RDY, 1);
    check("rst_irq", IRQ, 0);
    check("rst_rddata", RdData, 8'h00);
    nRST = 1'b1;
    repeat (3) @(negedge clk);
    cpu_read(1'b1, s);
    check("rst_status", s, 8'h06);

    mon_on = 1'b0;
    cpu_write(8'h00);
    repeat (40) @(negedge clk);
    check("tx_mid_frame_low", TxD, 0);
    #2 nRST = 1'b0;
    #1 check("tx_async_reset", TxD, 1);
    @(negedge clk); nRST = 1'b1;
    repeat (200) @(negedge clk);
    mon_on = 1'b1;
    cpu_read(1'b1, s);
    check("post_reset_status", s, 8'h06);

    @(negedge clk); nCS = 1'b0; ADDR = 1'b0; WrData = 8'hA5; nWR = 1'b0;
    @(negedge clk); nWR = 1'b1; tx_exp.push_back(8'hA5);
    @(negedge clk); nCS = 1'b1;
    check("rdy_low_after_commit", RDY, 0);
    @(negedge clk);
    check("rdy_back_high", RDY, 1);
    wait_tx_idle("tx_idle_a5");
    check("tx_drain_a5", tx_exp.size(), 0);

    for (int i = 0; i < 4; i++) begin
      cpu_write(tx_tab[i]);
      tx_exp.push_back(tx_tab[i]);
      wait_tx_idle("tx_idle_tab");
      check("tx_drain_tab", tx_exp.size(), 0);
    end

    start_q.delete();
    cpu_write(8'h11);
    tx_exp.push_back(8'h11);
    for (int i = 0; i < 17; i++) begin
      cpu_write(8'h20 + 8'(i));
      if (i < 16) tx_exp.push_back(8'h20 + 8'(i));
      if (i == 14) begin cpu_read(1'b1, s); check("tx_not_full_15", s[3], 0); end
      if (i == 15) begin cpu_read(1'b1, s); check("tx_full_16", s[3], 1); end
    end
    wait_tx_idle("tx_idle_burst");
    check("tx_drain_burst", tx_exp.size(), 0);
    check("burst_frames", start_q.size(), 17);
    bad = 0;
    for (int k = 1; k < start_q.size(); k++)
      if (start_q[k] - start_q[k-1] != 176) bad++;
    check("burst_gaps", bad, 0);

    for (int i = 0; i < 5; i++) begin
      send_rx(rx_tab[i].d, rx_tab[i].bad_par, rx_tab[i].bad_stop);
      if (!rx_tab[i].bad_stop) rx_exp.push_back(rx_tab[i].d);
      check("rx_irq", IRQ, 1);
      cpu_read(1'b1, s);
      check("rx_status", s, rx_tab[i].stat);
      if (!rx_tab[i].bad_stop) begin
        cpu_read(1'b0, s);
        check("rx_data", s, rx_exp.pop_front());
      end
      cpu_read(1'b1, s);
      check("rx_status_after", s, 8'h06);
      check("rx_irq_clear", IRQ, 0);
    end

    send_rx(8'h55, 1'b1, 1'b0);
    rx_exp.push_back(8'h55);
    send_rx(8'h99, 1'b0, 1'b1);
    cpu_read(1'b1, s);
    check("pe_fe_status", s, 8'hC7);
    cpu_read(1'b1, s);
    check("pe_fe_cleared", s, 8'h07);
    cpu_read(1'b0, s);
    check("pe_fe_data", s, rx_exp.pop_front());
    cpu_read(1'b1, s);
    check("pe_fe_empty", s, 8'h06);

    for (int i = 0; i < 17; i++) begin
      send_rx(8'h40 + 8'(i), 1'b0, 1'b0);
      if (i < 16) rx_exp.push_back(8'h40 + 8'(i));
      if (i == 15) begin cpu_read(1'b1, s); check("rx_full_16", s, 8'h17); end
    end
    cpu_read(1'b1, s);
    check("rx_overrun_status", s, 8'h37);
    for (int i = 0; i < 16; i++) begin
      cpu_read(1'b0, s);
      check("rx_overrun_data", s, rx_exp.pop_front());
    end
    cpu_read(1'b1, s);
    check("rx_overrun_drained", s, 8'h06);
    cpu_read(1'b0, s);
    check("rx_empty_reads_zero", s, 8'h00);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
